// File: rtl/icache_downstream_rsp_agent.sv
// Downstream linefill responder: queues icache miss requests, waits a fixed or LFSR-jittered latency,
// returns the backing-store line in request order. Optional jitter: ICACHE_DS_RSP_RAND_LAT_EN.
module icache_downstream_rsp_agent #(
  parameter int REQ_FIFO_DEPTH = 4,
  parameter int RSP_LATENCY    = 8,
  parameter int MEM_LINE_NUM   = 64,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 512,
  parameter int TXNID_WIDTH    = 8,
  parameter int OPCODE_WIDTH   = 4,
  parameter int IDX_WIDTH      = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            downstream_txreq_vld,
  output logic                            downstream_txreq_rdy,
  input  logic [OPCODE_WIDTH-1:0]         downstream_txreq_opcode,
  input  logic [TXNID_WIDTH-1:0]          downstream_txreq_txnid,
  input  logic [IDX_WIDTH-1:0]            downstream_txreq_entry_idx,
  input  logic [ADDR_WIDTH-1:0]           downstream_txreq_addr,
  output logic                            downstream_rxdat_vld,
  input  logic                            downstream_rxdat_rdy,
  output logic [OPCODE_WIDTH-1:0]         downstream_rxdat_opcode,
  output logic [TXNID_WIDTH-1:0]          downstream_rxdat_txnid,
  output logic [IDX_WIDTH-1:0]            downstream_rxdat_entry_idx,
  output logic [DATA_WIDTH-1:0]           downstream_rxdat_data,
  input  logic                            mem_wr_en,
  input  logic [$clog2(MEM_LINE_NUM)-1:0] mem_wr_line,
  input  logic [DATA_WIDTH-1:0]           mem_wr_data
);

  localparam int PTR_W  = $clog2(REQ_FIFO_DEPTH);
  localparam int LINE_W = $clog2(MEM_LINE_NUM);
  localparam int OFF_W  = $clog2(DATA_WIDTH / 8);
  localparam int CNT_W  = $clog2(RSP_LATENCY + 16) + 1;

  typedef struct packed {
    logic [OPCODE_WIDTH-1:0] opcode;
    logic [TXNID_WIDTH-1:0]  txnid;
    logic [IDX_WIDTH-1:0]    entry_idx;
    logic [LINE_W-1:0]       line;
  } req_t;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_SEND} state_t;

  state_t                  state_q, state_d;
  req_t                    fifo_q [REQ_FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]          count_q;
  req_t                    svc_q;
  logic [CNT_W-1:0]        cnt_q, cnt_init;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [DATA_WIDTH-1:0]   mem_q [MEM_LINE_NUM];
  logic                    fifo_full, fifo_empty, push, pop, capture;
  req_t                    push_req;
  logic                    unused_addr_bits;

  // Only the line-index bits of the address matter; upper bits wrap, offset is ignored.
  assign unused_addr_bits = ^{downstream_txreq_addr[ADDR_WIDTH-1:OFF_W+LINE_W],
                              downstream_txreq_addr[OFF_W-1:0]};

  assign push_req = '{opcode:    downstream_txreq_opcode,
                      txnid:     downstream_txreq_txnid,
                      entry_idx: downstream_txreq_entry_idx,
                      line:      downstream_txreq_addr[OFF_W +: LINE_W]};

  assign fifo_full            = (count_q == (PTR_W+1)'(REQ_FIFO_DEPTH));
  assign fifo_empty           = (count_q == '0);
  assign downstream_txreq_rdy = !rst && !fifo_full;
  assign push                 = downstream_txreq_vld && downstream_txreq_rdy;

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= push_req;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

`ifdef ICACHE_DS_RSP_RAND_LAT_EN
  logic [15:0] lfsr_q;

  // Fibonacci LFSR x^16+x^14+x^13+x^11, stepped once per dequeued request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      lfsr_q <= 16'hACE1;
    else if (pop) lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  assign cnt_init = CNT_W'(RSP_LATENCY - 1) + CNT_W'(lfsr_q[3:0]);
`else
  assign cnt_init = CNT_W'(RSP_LATENCY - 1);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: if (!fifo_empty) begin
        pop     = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: if (cnt_q == '0) begin
        capture = 1'b1;
        state_d = ST_SEND;
      end
      ST_SEND: if (downstream_rxdat_rdy) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      svc_q  <= '0;
      cnt_q  <= '0;
      data_q <= '0;
    end else begin
      if (pop) begin
        svc_q <= fifo_q[rd_ptr_q];
        cnt_q <= cnt_init;
      end else if (state_q == ST_WAIT && cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end
      if (capture) data_q <= mem_q[svc_q.line];
    end
  end

  // Backing store is never reset; a same-edge preload is seen by the next capture only.
  always_ff @(posedge clk) begin
    if (mem_wr_en) mem_q[mem_wr_line] <= mem_wr_data;
  end

  assign downstream_rxdat_vld       = (state_q == ST_SEND);
  assign downstream_rxdat_opcode    = svc_q.opcode;
  assign downstream_rxdat_txnid     = svc_q.txnid;
  assign downstream_rxdat_entry_idx = svc_q.entry_idx;
  assign downstream_rxdat_data      = data_q;

endmodule

// File: tb/tb_icache_downstream_rsp_agent.sv
// Bench for icache_downstream_rsp_agent: directed scenarios plus randomized traffic
// checked against a queue-based reference model of the backing store and response order.
module tb_icache_downstream_rsp_agent;

  localparam int LAT_MIN = 10;
`ifdef ICACHE_DS_RSP_RAND_LAT_EN
  localparam int LAT_MAX = 25;
`else
  localparam int LAT_MAX = 10;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         txreq_vld, txreq_rdy;
  logic [3:0]   txreq_opcode;
  logic [7:0]   txreq_txnid;
  logic [3:0]   txreq_entry_idx;
  logic [31:0]  txreq_addr;
  logic         rxdat_vld, rxdat_rdy;
  logic [3:0]   rxdat_opcode;
  logic [7:0]   rxdat_txnid;
  logic [3:0]   rxdat_entry_idx;
  logic [511:0] rxdat_data;
  logic         mem_wr_en;
  logic [5:0]   mem_wr_line;
  logic [511:0] mem_wr_data;

  int total = 0;
  int bad   = 0;
  logic [511:0] mem_model [64];

  typedef struct {
    logic [3:0]   opcode;
    logic [7:0]   txnid;
    logic [3:0]   idx;
    logic [511:0] data;
  } exp_t;

  icache_downstream_rsp_agent #(
    .REQ_FIFO_DEPTH(4), .RSP_LATENCY(8), .MEM_LINE_NUM(64), .ADDR_WIDTH(32),
    .DATA_WIDTH(512), .TXNID_WIDTH(8), .OPCODE_WIDTH(4), .IDX_WIDTH(4)
  ) dut (
    .clk                        (clk),
    .rst                        (rst),
    .downstream_txreq_vld       (txreq_vld),
    .downstream_txreq_rdy       (txreq_rdy),
    .downstream_txreq_opcode    (txreq_opcode),
    .downstream_txreq_txnid     (txreq_txnid),
    .downstream_txreq_entry_idx (txreq_entry_idx),
    .downstream_txreq_addr      (txreq_addr),
    .downstream_rxdat_vld       (rxdat_vld),
    .downstream_rxdat_rdy       (rxdat_rdy),
    .downstream_rxdat_opcode    (rxdat_opcode),
    .downstream_rxdat_txnid     (rxdat_txnid),
    .downstream_rxdat_entry_idx (rxdat_entry_idx),
    .downstream_rxdat_data      (rxdat_data),
    .mem_wr_en                  (mem_wr_en),
    .mem_wr_line                (mem_wr_line),
    .mem_wr_data                (mem_wr_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input int line, input logic [511:0] d);
    mem_wr_en   = 1'b1;
    mem_wr_line = line[5:0];
    mem_wr_data = d;
    tick();
    mem_wr_en      = 1'b0;
    mem_model[line] = d;
  endtask

  task automatic drive_req(input logic [3:0] op, input logic [7:0] id,
                           input logic [3:0] idx, input logic [31:0] addr);
    txreq_vld       = 1'b1;
    txreq_opcode    = op;
    txreq_txnid     = id;
    txreq_entry_idx = idx;
    txreq_addr      = addr;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++; if (rxdat_vld !== 1'b0) begin bad++; $display("FAIL reset_vld got=%b exp=0", rxdat_vld); end
    total++; if (txreq_rdy !== 1'b0) begin bad++; $display("FAIL reset_txreq_rdy got=%b exp=0", txreq_rdy); end
    total++; if ({rxdat_opcode, rxdat_txnid, rxdat_entry_idx} !== 16'h0) begin
      bad++; $display("FAIL reset_fields got=%h exp=0", {rxdat_opcode, rxdat_txnid, rxdat_entry_idx});
    end
    total++; if (rxdat_data !== '0) begin bad++; $display("FAIL reset_data got=%h exp=0", rxdat_data); end
    rst = 1'b0;
    tick();
    total++; if (txreq_rdy !== 1'b1) begin bad++; $display("FAIL post_reset_rdy got=%b exp=1", txreq_rdy); end
  endtask

  task automatic test_basic_latency();
    logic [511:0] d;
    int first, nvld;
    logic [7:0] id_seen;
    logic [3:0] idx_seen, op_seen;
    logic [511:0] data_seen;
    d = {16{32'hDEAD0003}};
    preload(3, d);
    rxdat_rdy = 1'b1;
    drive_req(4'h3, 8'd5, 4'd2, 32'hC0);
    total++; if (txreq_rdy !== 1'b1) begin bad++; $display("FAIL basic_accept got=%b exp=1", txreq_rdy); end
    tick();
    txreq_vld = 1'b0;
    first = -1; nvld = 0;
    id_seen = '0; idx_seen = '0; op_seen = '0; data_seen = '0;
    for (int k = 1; k <= LAT_MAX + 4; k++) begin
      if (rxdat_vld) begin
        if (first < 0) begin
          first = k; id_seen = rxdat_txnid; idx_seen = rxdat_entry_idx;
          op_seen = rxdat_opcode; data_seen = rxdat_data;
        end
        nvld++;
      end
      tick();
    end
    total++; if (first < LAT_MIN || first > LAT_MAX) begin
      bad++; $display("FAIL basic_latency got=%0d exp=[%0d,%0d]", first, LAT_MIN, LAT_MAX);
    end
    total++; if (nvld !== 1) begin bad++; $display("FAIL basic_vld_cycles got=%0d exp=1", nvld); end
    total++; if (id_seen !== 8'd5 || idx_seen !== 4'd2 || op_seen !== 4'h3) begin
      bad++; $display("FAIL basic_fields got=%h/%h/%h exp=5/2/3", id_seen, idx_seen, op_seen);
    end
    total++; if (data_seen !== d) begin bad++; $display("FAIL basic_data got=%h exp=%h", data_seen, d); end
  endtask

  task automatic test_backpressure();
    int hs;
    logic [511:0] snap;
    rxdat_rdy = 1'b0;
    drive_req(4'h1, 8'd6, 4'd1, 32'hC4);
    tick();
    txreq_vld = 1'b0;
    for (int k = 0; k < LAT_MAX + 4 && !rxdat_vld; k++) tick();
    total++; if (rxdat_vld !== 1'b1) begin bad++; $display("FAIL bp_wait_vld got=%b exp=1", rxdat_vld); end
    snap = rxdat_data;
    for (int k = 0; k < 5; k++) begin
      tick();
      total++; if (rxdat_vld !== 1'b1 || rxdat_txnid !== 8'd6 || rxdat_entry_idx !== 4'd1
                   || rxdat_data !== mem_model[3] || rxdat_data !== snap) begin
        bad++; $display("FAIL bp_stable cyc=%0d got vld=%b id=%h idx=%h exp vld=1 id=6 idx=1",
                        k, rxdat_vld, rxdat_txnid, rxdat_entry_idx);
      end
    end
    rxdat_rdy = 1'b1;
    hs = 0;
    for (int k = 0; k < 15; k++) begin
      if (rxdat_vld && rxdat_rdy) hs++;
      tick();
    end
    total++; if (hs !== 1) begin bad++; $display("FAIL bp_handshakes got=%0d exp=1", hs); end
  endtask

  task automatic test_fifo_full();
    int got;
    logic acc;
    for (int i = 0; i < 8; i++) preload(i, {16{$urandom}});
    rxdat_rdy = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive_req(i[3:0], i[7:0], i[3:0], i * 64);
      total++; if (txreq_rdy !== (i < 5)) begin
        bad++; $display("FAIL full_rdy req=%0d got=%b exp=%b", i, txreq_rdy, (i < 5));
      end
      if (i < 5) tick();
    end
    tick();
    rxdat_rdy = 1'b1;
    got = 0;
    for (int k = 0; k < 6 * (LAT_MAX + 2) + 20 && got < 6; k++) begin
      acc = txreq_vld && txreq_rdy;
      if (rxdat_vld && rxdat_rdy) begin
        total++; if (rxdat_txnid !== got[7:0] || rxdat_data !== mem_model[got]) begin
          bad++; $display("FAIL full_order got=%0d exp=%0d", rxdat_txnid, got);
        end
        got++;
      end
      tick();
      if (acc) txreq_vld = 1'b0;
    end
    total++; if (got !== 6) begin bad++; $display("FAIL full_count got=%0d exp=6", got); end
    txreq_vld = 1'b0;
  endtask

  task automatic test_wrap();
    logic [511:0] ones;
    ones = '1;
    preload(1, ones);
    rxdat_rdy = 1'b1;
    drive_req(4'h2, 8'd7, 4'd3, 32'h1040);
    tick();
    txreq_vld = 1'b0;
    for (int k = 0; k < LAT_MAX + 4 && !rxdat_vld; k++) tick();
    total++; if (rxdat_vld !== 1'b1 || rxdat_data !== ones || rxdat_txnid !== 8'd7) begin
      bad++; $display("FAIL wrap got vld=%b id=%h data=%h exp vld=1 id=7 data=all-ones",
                      rxdat_vld, rxdat_txnid, rxdat_data);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int nvld;
    rxdat_rdy = 1'b1;
    drive_req(4'h1, 8'd9, 4'd4, 32'h80);
    tick();
    txreq_vld = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    #1;
    total++; if (rxdat_vld !== 1'b0 || txreq_rdy !== 1'b0) begin
      bad++; $display("FAIL rstmid_immediate got vld=%b rdy=%b exp 0/0", rxdat_vld, txreq_rdy);
    end
    tick();
    tick();
    rst = 1'b0;
    tick();
    total++; if (txreq_rdy !== 1'b1) begin bad++; $display("FAIL rstmid_rdy got=%b exp=1", txreq_rdy); end
    nvld = 0;
    for (int k = 0; k < LAT_MAX + 10; k++) begin
      if (rxdat_vld) nvld++;
      tick();
    end
    total++; if (nvld !== 0) begin bad++; $display("FAIL rstmid_dropped got=%0d exp=0", nvld); end
  endtask

  task automatic test_back_to_back();
    int rises[$];
    logic prev;
    rxdat_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_req(4'h0, 8'(20 + i), 4'(i), 32'(i * 64));
      total++; if (txreq_rdy !== 1'b1) begin bad++; $display("FAIL b2b_accept req=%0d got=0 exp=1", i); end
      tick();
    end
    txreq_vld = 1'b0;
    prev = 1'b0;
    for (int k = 3; k < 3 * (LAT_MAX + 2) + 10; k++) begin
      if (rxdat_vld && !prev) rises.push_back(k);
      prev = rxdat_vld;
      tick();
    end
    total++; if (rises.size() !== 3) begin
      bad++; $display("FAIL b2b_count got=%0d exp=3", rises.size());
    end else begin
      for (int i = 1; i < 3; i++) begin
        total++; if (rises[i] - rises[i-1] < LAT_MIN || rises[i] - rises[i-1] > LAT_MAX) begin
          bad++; $display("FAIL b2b_gap idx=%0d got=%0d exp=[%0d,%0d]", i, rises[i] - rises[i-1],
                          LAT_MIN, LAT_MAX);
        end
      end
    end
  endtask

  task automatic test_latency_window();
    int lat;
    rxdat_rdy = 1'b1;
    for (int r = 0; r < 20; r++) begin
      drive_req(4'h5, 8'(100 + r), 4'(r), 32'(r * 64));
      tick();
      txreq_vld = 1'b0;
      lat = 1;
      while (!rxdat_vld && lat < LAT_MAX + 6) begin tick(); lat++; end
      total++; if (lat < LAT_MIN || lat > LAT_MAX || rxdat_txnid !== 8'(100 + r)) begin
        bad++; $display("FAIL latwin req=%0d got lat=%0d id=%0d exp lat=[%0d,%0d] id=%0d",
                        r, lat, rxdat_txnid, LAT_MIN, LAT_MAX, 100 + r);
      end
      tick();
    end
  endtask

  task automatic test_random_traffic();
    exp_t q[$];
    exp_t e;
    int sent, got;
    logic acc;
    for (int l = 0; l < 64; l++) begin
      logic [511:0] d;
      for (int w = 0; w < 16; w++) d[w*32 +: 32] = $urandom;
      preload(l, d);
    end
    sent = 0; got = 0;
    txreq_vld = 1'b0;
    for (int k = 0; k < 40 * (LAT_MAX + 2) * 3 && got < 40; k++) begin
      if (!txreq_vld && sent < 40 && $urandom_range(0, 2) != 0)
        drive_req(4'($urandom), 8'($urandom), 4'($urandom), $urandom);
      rxdat_rdy = ($urandom_range(0, 3) != 0);
      acc = txreq_vld && txreq_rdy;
      if (acc) begin
        e.opcode = txreq_opcode; e.txnid = txreq_txnid; e.idx = txreq_entry_idx;
        e.data = mem_model[txreq_addr[11:6]];
        q.push_back(e);
        sent++;
      end
      if (rxdat_vld && rxdat_rdy) begin
        total++;
        if (q.size() == 0) begin
          bad++; $display("FAIL rand_unexpected id=%h exp=none", rxdat_txnid);
        end else begin
          e = q.pop_front();
          if (rxdat_txnid !== e.txnid || rxdat_entry_idx !== e.idx || rxdat_opcode !== e.opcode
              || rxdat_data !== e.data) begin
            bad++; $display("FAIL rand_rsp n=%0d got id=%h idx=%h op=%h exp id=%h idx=%h op=%h",
                            got, rxdat_txnid, rxdat_entry_idx, rxdat_opcode, e.txnid, e.idx, e.opcode);
          end
        end
        got++;
      end
      tick();
      if (acc) txreq_vld = 1'b0;
    end
    total++; if (got !== 40) begin bad++; $display("FAIL rand_count got=%0d exp=40", got); end
    txreq_vld = 1'b0;
    rxdat_rdy = 1'b1;
  endtask

  initial begin
    rst = 1'b1; txreq_vld = 1'b0; txreq_opcode = '0; txreq_txnid = '0; txreq_entry_idx = '0;
    txreq_addr = '0; rxdat_rdy = 1'b0; mem_wr_en = 1'b0; mem_wr_line = '0; mem_wr_data = '0;
    test_reset();
    test_basic_latency();
    repeat (2) tick();
    test_backpressure();
    repeat (2) tick();
    test_fifo_full();
    repeat (2) tick();
    test_wrap();
    repeat (2) tick();
    test_reset_mid();
    repeat (2) tick();
    test_back_to_back();
    repeat (2) tick();
    test_latency_window();
    repeat (2) tick();
    test_random_traffic();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
